// File: rtl/adg_mux_pkg.sv
// rtl/adg_mux_pkg.sv - shared state and mode encodings for the mux sequencer
package adg_mux_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DWELL  = 3'd4
    } state_t;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_IDLE  = 2'd0;
    localparam mode_t MODE_SWEEP = 2'd1;
    localparam mode_t MODE_STEP  = 2'd2;
    localparam mode_t MODE_FIXED = 2'd3;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter with zero flag for phase timing
module phase_timer #(
    parameter int CNT_W = 24
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    // Load on phase entry, otherwise count down and park at zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/adg_mux_sequencer.sv
// rtl/adg_mux_sequencer.sv - ADG732-class mux channel sequencer with break-before-make
module adg_mux_sequencer
    import adg_mux_pkg::*;
#(
    parameter int NUM_CH       = 32,
    parameter int CH_W         = 5,
    parameter int CNT_W        = 24,
    parameter int DWELL_CYCLES = 10000000,
    parameter int SETUP_CYCLES = 2,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_run,
    input  logic [1:0]      i_mode,
    input  logic            i_step,
    input  logic [CH_W-1:0] i_fixed_ch,
    output logic [CH_W-1:0] o_set_ch,
    output logic            o_en_n,
    output logic            o_cs_n,
    output logic            o_wr_n,
    output logic [CH_W-1:0] o_cur_ch,
    output logic            o_ch_valid,
    output logic            o_ready,
    output logic            o_sweep_done,
    output logic            o_busy
);

    if (NUM_CH < 2 || NUM_CH > (1 << CH_W)) begin : g_bad_num_ch
        $error("adg_mux_sequencer: NUM_CH must be in 2..2**CH_W");
    end
    if (DWELL_CYCLES < 1 || DWELL_CYCLES > (1 << CNT_W) - 1) begin : g_bad_dwell
        $error("adg_mux_sequencer: DWELL_CYCLES must be in 1..2**CNT_W-1");
    end
    if (SETUP_CYCLES < 1 || PULSE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_phase
        $error("adg_mux_sequencer: SETUP/PULSE/HOLD_CYCLES must be >= 1");
    end
    if (SETUP_CYCLES > (1 << CNT_W) || PULSE_CYCLES > (1 << CNT_W) ||
        HOLD_CYCLES > (1 << CNT_W)) begin : g_bad_phase_w
        $error("adg_mux_sequencer: phase length exceeds counter width");
    end

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CH_W-1:0]   r_target;
    logic [CH_W-1:0]   w_target_nxt;
    logic [CH_W-1:0]   r_set_ch;
    logic [CH_W-1:0]   r_cur_ch;
    logic              r_en_n;
    logic              r_cs_n;
    logic              r_wr_n;
    logic              r_ch_valid;
    logic              r_ready;
    logic              r_sweep_done;
    logic              r_busy;
    logic              w_active;
    logic              w_advance;
    logic              w_wrap;
    logic              w_tmr_done;
    logic              w_tmr_load;
    logic [CNT_W-1:0]  w_tmr_val;
    logic [CH_W-1:0]   w_fixed_clamped;
    logic [CH_W-1:0]   w_next_ch;

    assign w_active        = i_run && (i_mode != MODE_IDLE);
    assign w_fixed_clamped = (i_fixed_ch > LAST_CH) ? LAST_CH : i_fixed_ch;
    assign w_next_ch       = (r_cur_ch == LAST_CH) ? '0 : r_cur_ch + CH_W'(1);
    assign w_tmr_load      = (w_state_nxt != r_state);

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    // Next-state and next-target; a started write always runs to the end of HOLD
    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_advance    = 1'b0;
        w_wrap       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_active) begin
                    w_state_nxt  = ST_SETUP;
                    w_target_nxt = (i_mode == MODE_FIXED) ? w_fixed_clamped : '0;
                end
            end
            ST_SETUP:  if (w_tmr_done) w_state_nxt = ST_STROBE;
            ST_STROBE: if (w_tmr_done) w_state_nxt = ST_HOLD;
            ST_HOLD:   if (w_tmr_done) w_state_nxt = w_active ? ST_DWELL : ST_IDLE;
            ST_DWELL: begin
                if (!w_active) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_mode == MODE_FIXED) begin
                    if (w_fixed_clamped != r_cur_ch) begin
                        w_state_nxt  = ST_SETUP;
                        w_target_nxt = w_fixed_clamped;
                    end
                end else if ((i_mode == MODE_SWEEP && w_tmr_done) ||
                             (i_mode == MODE_STEP && r_ready && i_step)) begin
                    w_advance = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_advance) begin
            w_state_nxt  = ST_SETUP;
            w_target_nxt = w_next_ch;
            w_wrap       = (r_cur_ch == LAST_CH);
        end
    end

    // Phase length loaded into the timer on entry to each state (N cycles -> N-1)
    always_comb begin
        w_tmr_val = '0;
        case (w_state_nxt)
            ST_SETUP:  w_tmr_val = CNT_W'(SETUP_CYCLES - 1);
            ST_STROBE: w_tmr_val = CNT_W'(PULSE_CYCLES - 1);
            ST_HOLD:   w_tmr_val = CNT_W'(HOLD_CYCLES - 1);
            ST_DWELL:  w_tmr_val = CNT_W'(DWELL_CYCLES - 1);
            default:   w_tmr_val = '0;
        endcase
    end

    // State register and registered pin outputs decoded from the upcoming state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_target     <= '0;
            r_set_ch     <= '0;
            r_cur_ch     <= '0;
            r_en_n       <= 1'b1;
            r_cs_n       <= 1'b1;
            r_wr_n       <= 1'b1;
            r_ch_valid   <= 1'b0;
            r_ready      <= 1'b0;
            r_sweep_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_target     <= w_target_nxt;
            if (w_state_nxt == ST_SETUP && r_state != ST_SETUP) begin
                r_set_ch <= w_target_nxt;
            end
            if (r_state == ST_HOLD && w_tmr_done) begin
                r_cur_ch <= r_target;
            end
            r_en_n       <= (w_state_nxt != ST_DWELL);
            r_cs_n       <= !(w_state_nxt == ST_SETUP || w_state_nxt == ST_STROBE ||
                              w_state_nxt == ST_HOLD);
            r_wr_n       <= (w_state_nxt != ST_STROBE);
            r_ch_valid   <= (w_state_nxt == ST_DWELL);
            r_ready      <= (r_state == ST_DWELL) && w_tmr_done &&
                            (w_state_nxt == ST_DWELL) && (i_mode == MODE_STEP);
            r_sweep_done <= w_wrap;
            r_busy       <= (w_state_nxt != ST_IDLE);
        end
    end

    assign o_set_ch     = r_set_ch;
    assign o_en_n       = r_en_n;
    assign o_cs_n       = r_cs_n;
    assign o_wr_n       = r_wr_n;
    assign o_cur_ch     = r_cur_ch;
    assign o_ch_valid   = r_ch_valid;
    assign o_ready      = r_ready;
    assign o_sweep_done = r_sweep_done;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_adg_mux_sequencer.sv
// tb/tb_adg_mux_sequencer.sv - self-checking bench for adg_mux_sequencer
module tb_adg_mux_sequencer;

    localparam int NCH = 4;
    localparam int TS  = 2;
    localparam int TP  = 2;
    localparam int TH  = 2;
    localparam int TD  = 8;
    localparam int RP  = TS + TP + TH;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [1:0] mode;
    logic       step;
    logic [2:0] fixed_ch;
    logic [2:0] o_set_ch;
    logic [2:0] o_cur_ch;
    logic       o_en_n, o_cs_n, o_wr_n, o_ch_valid, o_ready, o_sweep_done, o_busy;

    int n_total = 0;
    int n_pass  = 0;
    int bbm_viol = 0;

    always #5 clk = ~clk;

    adg_mux_sequencer #(
        .NUM_CH(NCH), .CH_W(3), .CNT_W(8), .DWELL_CYCLES(TD),
        .SETUP_CYCLES(TS), .PULSE_CYCLES(TP), .HOLD_CYCLES(TH)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_mode(mode), .i_step(step),
        .i_fixed_ch(fixed_ch), .o_set_ch(o_set_ch), .o_en_n(o_en_n), .o_cs_n(o_cs_n),
        .o_wr_n(o_wr_n), .o_cur_ch(o_cur_ch), .o_ch_valid(o_ch_valid), .o_ready(o_ready),
        .o_sweep_done(o_sweep_done), .o_busy(o_busy)
    );

    // Reference model: m_pos = -1 idle, 0..RP-1 position inside a reprogram,
    // RP.. = dwell (age = m_pos-RP, saturated)
    int         m_pos;
    logic [2:0] m_target, m_cur, m_set;
    logic       m_ready, m_sd;

    task automatic model_reset();
        m_pos = -1; m_target = 3'd0; m_cur = 3'd0; m_set = 3'd0; m_ready = 1'b0; m_sd = 1'b0;
    endtask

    task automatic model_start(input logic [2:0] t);
        m_pos = 0; m_target = t; m_set = t;
    endtask

    task automatic model_step();
        logic       act, nr, nsd, expired;
        logic [2:0] cl;
        act = run && (mode != 2'd0);
        cl  = (fixed_ch > 3'(NCH - 1)) ? 3'(NCH - 1) : fixed_ch;
        nr  = 1'b0;
        nsd = 1'b0;
        if (m_pos < 0) begin
            if (act) model_start((mode == 2'd3) ? cl : 3'd0);
        end else if (m_pos < RP) begin
            if (m_pos == RP - 1) begin
                m_cur = m_target;
                m_pos = act ? RP : -1;
            end else begin
                m_pos++;
            end
        end else begin
            expired = (m_pos - RP) >= TD - 1;
            if (!act) begin
                m_pos = -1;
            end else if ((mode == 2'd1 && expired) || (mode == 2'd2 && m_ready && step)) begin
                nsd = (m_cur == 3'(NCH - 1));
                model_start(nsd ? 3'd0 : 3'(m_cur + 3'd1));
            end else if (mode == 2'd3 && cl != m_cur) begin
                model_start(cl);
            end else begin
                nr = (mode == 2'd2) && expired;
                if (m_pos < RP + TD) m_pos++;
            end
        end
        m_ready = nr;
        m_sd    = nsd;
    endtask

    function automatic logic [12:0] exp_vec();
        logic [4:0] p;
        if (m_pos < 0)       p = 5'b11100;
        else if (m_pos < RP) p = {1'b1, 1'b0, !(m_pos >= TS && m_pos < TS + TP), 1'b0, 1'b1};
        else                 p = 5'b01111;
        return {m_set, m_cur, p[4:2], p[1], m_ready, m_sd, p[0]};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {o_set_ch, o_cur_ch, o_en_n, o_cs_n, o_wr_n, o_ch_valid, o_ready, o_sweep_done, o_busy};
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        @(negedge clk);
        check("model", dut_vec(), exp_vec());
        if (!o_cs_n && (!o_en_n || o_ch_valid)) bbm_viol++;
    endtask

    typedef struct {
        int         n;
        logic [2:0] set_ch;
        logic [2:0] cur_ch;
        logic [4:0] pins;   // en_n, cs_n, wr_n, ch_valid, sweep_done
    } vec_t;

    vec_t tbl[14];

    initial begin
        int         cnt, k, wr_low, wr_falls, sd_cnt, guard;
        logic       prev_wr, v_seen;
        tbl[0]  = '{1,  3'd0, 3'd0, 5'b10100};
        tbl[1]  = '{3,  3'd0, 3'd0, 5'b10000};
        tbl[2]  = '{5,  3'd0, 3'd0, 5'b10100};
        tbl[3]  = '{7,  3'd0, 3'd0, 5'b01110};
        tbl[4]  = '{14, 3'd0, 3'd0, 5'b01110};
        tbl[5]  = '{15, 3'd1, 3'd0, 5'b10100};
        tbl[6]  = '{17, 3'd1, 3'd0, 5'b10000};
        tbl[7]  = '{21, 3'd1, 3'd1, 5'b01110};
        tbl[8]  = '{43, 3'd3, 3'd2, 5'b10100};
        tbl[9]  = '{56, 3'd3, 3'd3, 5'b01110};
        tbl[10] = '{57, 3'd0, 3'd3, 5'b10101};
        tbl[11] = '{58, 3'd0, 3'd3, 5'b10100};
        tbl[12] = '{63, 3'd0, 3'd0, 5'b01110};
        tbl[13] = '{71, 3'd1, 3'd0, 5'b10100};

        rst_n = 1'b0; run = 1'b0; mode = 2'd0; step = 1'b0; fixed_ch = 3'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_state", dut_vec(), 13'b000_000_111_0000);

        // Continuous sweep against the hand-built timing table
        run = 1'b1; mode = 2'd1; rst_n = 1'b1;
        wr_falls = 0; wr_low = 0; sd_cnt = 0; prev_wr = 1'b1;
        for (int n = 1; n <= 71; n++) begin
            tick();
            if (!o_wr_n) wr_low++;
            if (prev_wr && !o_wr_n) wr_falls++;
            prev_wr = o_wr_n;
            if (o_sweep_done) sd_cnt++;
            for (int i = 0; i < 14; i++)
                if (tbl[i].n == n)
                    check($sformatf("sweep_n%0d", n),
                          {o_set_ch, o_cur_ch, o_en_n, o_cs_n, o_wr_n, o_ch_valid, o_sweep_done},
                          {tbl[i].set_ch, tbl[i].cur_ch, tbl[i].pins});
        end
        check("sweep_wr_low_cycles", wr_low, 10);
        check("sweep_wr_falls", wr_falls, 5);
        check("sweep_done_pulses", sd_cnt, 1);

        // Back to idle
        run = 1'b0;
        guard = 0;
        while (o_busy && guard < 20) begin tick(); guard++; end
        check("idle_after_run_drop", o_busy, 0);

        // Single-step: early step ignored, ready after full dwell, 6-cycle reprogram
        run = 1'b1; mode = 2'd2;
        guard = 0;
        while (!o_ch_valid && guard < 20) begin tick(); guard++; end
        check("step_first_valid", o_ch_valid, 1);
        k = 0;
        repeat (3) begin tick(); k++; end
        step = 1'b1; tick(); k++; step = 1'b0;
        check("step_early_ignored", {o_ch_valid, o_cur_ch}, {1'b1, 3'd0});
        guard = 0;
        while (!o_ready && guard < 20) begin tick(); k++; guard++; end
        check("step_ready_latency", k, TD);
        step = 1'b1; tick(); step = 1'b0;
        cnt = 0;
        while (!o_ch_valid && cnt < 20) begin cnt++; tick(); end
        check("step_reprogram_cycles", cnt, RP);
        check("step_advanced", o_cur_ch, 1);

        // Fixed channel, including clamp of an out-of-range request
        mode = 2'd3; fixed_ch = 3'd2;
        tick();
        guard = 0;
        while (!o_ch_valid && guard < 20) begin tick(); guard++; end
        check("fixed_ch2", o_cur_ch, 2);
        cnt = 0;
        repeat (20) begin tick(); if (!o_cs_n) cnt++; end
        check("fixed_no_reprogram", cnt, 0);
        fixed_ch = 3'd7;
        tick();
        guard = 0;
        while (!o_ch_valid && guard < 20) begin tick(); guard++; end
        check("fixed_clamped", {o_cur_ch, o_set_ch}, {3'd3, 3'd3});

        // run dropped during STROBE: pulse completes, no dwell
        run = 1'b0; tick(); tick();
        run = 1'b1; mode = 2'd1;
        guard = 0;
        while (o_wr_n && guard < 20) begin tick(); guard++; end
        run = 1'b0;
        wr_low = 1; v_seen = 1'b0;
        repeat (10) begin tick(); if (!o_wr_n) wr_low++; if (o_ch_valid) v_seen = 1'b1; end
        check("drop_wr_full_width", wr_low, TP);
        check("drop_no_valid", v_seen, 0);
        check("drop_idle_pins", {o_busy, o_en_n, o_cs_n}, 3'b011);

        // Asynchronous reset mid-STROBE
        run = 1'b1; mode = 2'd1;
        guard = 0;
        while (o_wr_n && guard < 20) begin tick(); guard++; end
        #2 rst_n = 1'b0;
        #1 check("async_reset_pins", {o_wr_n, o_cs_n, o_en_n, o_set_ch, o_busy}, {3'b111, 3'd0, 1'b0});
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("restart_ch0", {o_set_ch, o_cs_n}, {3'd0, 1'b0});
        guard = 0;
        while (!o_ch_valid && guard < 20) begin tick(); guard++; end
        check("restart_cur0", o_cur_ch, 0);

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) fixed_ch = 3'($urandom_range(0, 7));
            run  = ($urandom_range(0, 49) != 0);
            step = ($urandom_range(0, 3) == 0);
            tick();
        end
        step = 1'b0;

        check("break_before_make", bbm_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
